// File: rtl/acquisition_sequencer_if.sv
// Control/data-side signal bundle for the acquisition sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface acquisition_sequencer_if #(
  parameter int REG_DATA_WIDTH = 16
);
  logic                      start_i;
  logic                      stop_i;
  logic                      sample_rdy_i;
  logic                      trigger_i;
  logic [REG_DATA_WIDTH-1:0] pretrigger_i;
  logic [REG_DATA_WIDTH-1:0] num_samples_i;
  logic                      chA_on_i;
  logic                      chB_on_i;
  logic                      chA_eof_i;
  logic                      chB_eof_i;
  logic                      we_o;
  logic                      rqst_chA_o;
  logic                      rqst_chB_o;
  logic                      triggered_o;
  logic                      busy_o;
  logic                      done_o;
  logic [2:0]                state_o;

  modport slave (
    input  start_i, stop_i, sample_rdy_i, trigger_i, pretrigger_i, num_samples_i,
           chA_on_i, chB_on_i, chA_eof_i, chB_eof_i,
    output we_o, rqst_chA_o, rqst_chB_o, triggered_o, busy_o, done_o, state_o
  );

  modport master (
    output start_i, stop_i, sample_rdy_i, trigger_i, pretrigger_i, num_samples_i,
           chA_on_i, chB_on_i, chA_eof_i, chB_eof_i,
    input  we_o, rqst_chA_o, rqst_chB_o, triggered_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/acquisition_sequencer.sv
// Oscilloscope capture sequencer: pre-trigger fill, armed wait, post-trigger count,
// then optional per-channel readout requests. All outputs are registered.
module acquisition_sequencer #(
  parameter int REG_DATA_WIDTH = 16,
  parameter bit AUTO_READOUT   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  acquisition_sequencer_if.slave bus
);
  localparam int W = REG_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    ARMED  = 3'd2,
    POST   = 3'd3,
    READ_A = 3'd4,
    READ_B = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic [W-1:0] pre_target, pre_target_n;
  logic [W-1:0] post_target, post_target_n;
  logic [W-1:0] num_m1, pre_clamp;
  logic         rd_en, rd_en_n;
  logic         we_q, we_n;
  logic         rqst_a_q, rqst_a_n;
  logic         rqst_b_q, rqst_b_n;
  logic         trig_q, trig_n;
  logic         done_q, done_n;

  // pre_target never reaches num_samples, so at least the trigger sample is post-trigger
  always_comb begin
    num_m1    = bus.num_samples_i - W'(1);
    pre_clamp = (bus.pretrigger_i < num_m1) ? bus.pretrigger_i : num_m1;
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    pre_target_n  = pre_target;
    post_target_n = post_target;
    rd_en_n       = rd_en;
    rqst_a_n      = 1'b0;
    rqst_b_n      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_i && !bus.stop_i && (bus.num_samples_i != '0)) begin
          state_n       = PRE;
          cnt_n         = '0;
          pre_target_n  = pre_clamp;
          post_target_n = bus.num_samples_i - pre_clamp;
        end
      end
      PRE: begin
        if (cnt == pre_target)     state_n = ARMED;
        else if (bus.sample_rdy_i) cnt_n   = cnt + W'(1);
      end
      ARMED: begin
        if (bus.trigger_i && bus.sample_rdy_i) begin
          state_n = POST;
          cnt_n   = W'(1);
        end
      end
      POST: begin
        if (cnt == post_target)    state_n = AUTO_READOUT ? READ_A : DONE;
        else if (bus.sample_rdy_i) cnt_n   = cnt + W'(1);
      end
      READ_A:  if (!rd_en || bus.chA_eof_i) state_n = READ_B;
      READ_B:  if (!rd_en || bus.chB_eof_i) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (bus.stop_i && (state != IDLE)) state_n = IDLE;

    // Channel enable is sampled once on entry to its read state and held for the wait
    if (state_n != state) begin
      if (state_n == READ_A) begin
        rd_en_n  = bus.chA_on_i;
        rqst_a_n = bus.chA_on_i;
      end else if (state_n == READ_B) begin
        rd_en_n  = bus.chB_on_i;
        rqst_b_n = bus.chB_on_i;
      end
    end

    we_n   = (state_n == PRE) || (state_n == ARMED) || (state_n == POST);
    trig_n = (state_n == POST) || (state_n == READ_A) || (state_n == READ_B);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pre_target  <= '0;
      post_target <= '0;
      rd_en       <= 1'b0;
      we_q        <= 1'b0;
      rqst_a_q    <= 1'b0;
      rqst_b_q    <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pre_target  <= pre_target_n;
      post_target <= post_target_n;
      rd_en       <= rd_en_n;
      we_q        <= we_n;
      rqst_a_q    <= rqst_a_n;
      rqst_b_q    <= rqst_b_n;
      trig_q      <= trig_n;
      done_q      <= done_n;
    end
  end

  assign bus.we_o        = we_q;
  assign bus.rqst_chA_o  = rqst_a_q;
  assign bus.rqst_chB_o  = rqst_b_q;
  assign bus.triggered_o = trig_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = (state != IDLE);
  assign bus.state_o     = state;
endmodule

// File: tb/tb_acquisition_sequencer.sv
// Directed bench for acquisition_sequencer: one AUTO_READOUT=1 and one AUTO_READOUT=0
// instance share stimulus; readout/done pulses are checked against per-instance queues.
module tb_acquisition_sequencer;
  localparam int W = 16;
  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_ARMED = 3'd2, S_POST = 3'd3,
                         S_READ_A = 3'd4, S_READ_B = 3'd5, S_DONE = 3'd6;
  localparam logic [2:0] EV_A = 3'b001, EV_B = 3'b010, EV_D = 3'b100;

  logic clk = 1'b0;
  logic rst, rst0_x, rst0;
  logic start, stop, sample_rdy, trigger, cha_on, chb_on, cha_eof, chb_eof;
  logic [W-1:0] pretrig, num;

  always #5 clk = ~clk;
  assign rst0 = rst | rst0_x;

  acquisition_sequencer_if #(.REG_DATA_WIDTH(W)) bus1 ();
  acquisition_sequencer_if #(.REG_DATA_WIDTH(W)) bus0 ();

  assign bus1.start_i = start;        assign bus0.start_i = start;
  assign bus1.stop_i = stop;          assign bus0.stop_i = stop;
  assign bus1.sample_rdy_i = sample_rdy; assign bus0.sample_rdy_i = sample_rdy;
  assign bus1.trigger_i = trigger;    assign bus0.trigger_i = trigger;
  assign bus1.pretrigger_i = pretrig; assign bus0.pretrigger_i = pretrig;
  assign bus1.num_samples_i = num;    assign bus0.num_samples_i = num;
  assign bus1.chA_on_i = cha_on;      assign bus0.chA_on_i = cha_on;
  assign bus1.chB_on_i = chb_on;      assign bus0.chB_on_i = chb_on;
  assign bus1.chA_eof_i = cha_eof;    assign bus0.chA_eof_i = cha_eof;
  assign bus1.chB_eof_i = chb_eof;    assign bus0.chB_eof_i = chb_eof;

  acquisition_sequencer #(.REG_DATA_WIDTH(W), .AUTO_READOUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  acquisition_sequencer #(.REG_DATA_WIDTH(W), .AUTO_READOUT(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.slave));

  int pass_cnt = 0, fail_cnt = 0, check_cnt = 0;
  logic [2:0] exp1[$];
  logic [2:0] exp0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    check_cnt++;
    assert (obs === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [5:0] outs1();
    return {bus1.we_o, bus1.rqst_chA_o, bus1.rqst_chB_o, bus1.triggered_o, bus1.busy_o, bus1.done_o};
  endfunction
  function automatic logic [5:0] outs0();
    return {bus0.we_o, bus0.rqst_chA_o, bus0.rqst_chB_o, bus0.triggered_o, bus0.busy_o, bus0.done_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Samples every 3rd cycle; trigger rides on sample trig_at and also on sample 2
  // (the latter must be ignored while still in PRE). Counts samples seen in PRE/POST.
  task automatic run_until(input logic [2:0] target, input int trig_at, input int budget,
                           output int n_pre, output int n_post);
    int sidx = 0;
    n_pre = 0;
    n_post = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      sample_rdy = (cyc % 3 == 0);
      trigger = 1'b0;
      if (sample_rdy) begin
        sidx++;
        trigger = (sidx == trig_at) || (sidx == 2);
        if (bus1.state_o == S_PRE)  n_pre++;
        if (bus1.state_o == S_POST) n_post++;
      end
      step();
      if (bus1.state_o == target) break;
    end
    sample_rdy = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic finish_read(input int budget);
    for (int cyc = 0; cyc < budget; cyc++) begin
      cha_eof = (bus1.state_o == S_READ_A);
      chb_eof = (bus1.state_o == S_READ_B);
      step();
      if (bus1.state_o == S_IDLE) break;
    end
    cha_eof = 1'b0;
    chb_eof = 1'b0;
    chk("finish_idle", bus1.state_o, S_IDLE);
  endtask

  always @(negedge clk) begin
    logic [2:0] ev1, ev0;
    ev1 = {bus1.done_o, bus1.rqst_chB_o, bus1.rqst_chA_o};
    ev0 = {bus0.done_o, bus0.rqst_chB_o, bus0.rqst_chA_o};
    if (ev1 != 3'b000) begin
      if (exp1.size() == 0) chk("ar1_unexpected_event", ev1, 3'b000);
      else chk("ar1_event", ev1, exp1.pop_front());
    end
    if (ev0 != 3'b000) begin
      if (exp0.size() == 0) chk("ar0_unexpected_event", ev0, 3'b000);
      else chk("ar0_event", ev0, exp0.pop_front());
    end
  end

  initial begin
    int npre, npost;
    rst = 1'b1; rst0_x = 1'b0; start = 1'b0; stop = 1'b0; sample_rdy = 1'b0; trigger = 1'b0;
    pretrig = '0; num = '0; cha_on = 1'b0; chb_on = 1'b0; cha_eof = 1'b0; chb_eof = 1'b0;
    step(); step();
    chk("reset_state", bus1.state_o, S_IDLE);
    chk("reset_outs", outs1(), 6'd0);
    chk("reset_outs_ar0", outs0(), 6'd0);
    rst = 1'b0;
    step();

    // Nominal capture, pretrigger 4 of 10, trigger on 7th sample
    pretrig = 16'd4; num = 16'd10; cha_on = 1'b1; chb_on = 1'b1;
    exp1.push_back(EV_A); exp1.push_back(EV_B); exp1.push_back(EV_D);
    exp0.push_back(EV_D);
    start = 1'b1; step(); start = 1'b0;
    chk("nom_pre_state", bus1.state_o, S_PRE);
    chk("nom_we_start", bus1.we_o, 1'b1);
    chk("nom_busy", bus1.busy_o, 1'b1);
    pretrig = 16'd1; num = 16'd3;
    run_until(S_READ_A, 7, 200, npre, npost);
    chk("nom_reach_read_a", bus1.state_o, S_READ_A);
    chk("nom_pre_samples", npre, 4);
    chk("nom_post_samples", npost, 5);
    chk("nom_we_fall", bus1.we_o, 1'b0);
    chk("nom_rqst_a", bus1.rqst_chA_o, 1'b1);
    chk("nom_triggered", bus1.triggered_o, 1'b1);
    chk("ar0_done_state", bus0.state_o, S_DONE);
    chk("ar0_done_pulse", bus0.done_o, 1'b1);
    chk("ar0_we_fall", bus0.we_o, 1'b0);
    chb_eof = 1'b1; step(); step(); chb_eof = 1'b0;
    chk("nom_wait_a", bus1.state_o, S_READ_A);
    chk("nom_rqst_a_once", bus1.rqst_chA_o, 1'b0);
    chk("ar0_back_idle", bus0.state_o, S_IDLE);
    cha_eof = 1'b1; step(); cha_eof = 1'b0;
    chk("nom_read_b", bus1.state_o, S_READ_B);
    chk("nom_rqst_b", bus1.rqst_chB_o, 1'b1);
    step();
    chk("nom_rqst_b_once", bus1.rqst_chB_o, 1'b0);
    chk("nom_wait_b", bus1.state_o, S_READ_B);
    chb_eof = 1'b1; step(); chb_eof = 1'b0;
    chk("nom_done_state", bus1.state_o, S_DONE);
    chk("nom_done_pulse", bus1.done_o, 1'b1);
    chk("nom_trig_clear", bus1.triggered_o, 1'b0);
    step();
    chk("nom_idle", bus1.state_o, S_IDLE);
    chk("nom_idle_outs", outs1(), 6'd0);

    // Pretrigger clamp: 20 requested of 8 -> 7 pre samples, post_target 1
    pretrig = 16'd20; num = 16'd8;
    exp1.push_back(EV_A); exp1.push_back(EV_B); exp1.push_back(EV_D);
    exp0.push_back(EV_D);
    start = 1'b1; step(); start = 1'b0;
    run_until(S_READ_A, 8, 200, npre, npost);
    chk("clamp_reach_read_a", bus1.state_o, S_READ_A);
    chk("clamp_pre_samples", npre, 7);
    chk("clamp_post_samples", npost, 0);
    finish_read(20);

    // Zero-length request is ignored
    num = 16'd0; pretrig = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_state", bus1.state_o, S_IDLE);
    chk("zero_outs", outs1(), 6'd0);
    chk("zero_state_ar0", bus0.state_o, S_IDLE);

    // Abort while armed
    pretrig = 16'd1; num = 16'd4;
    start = 1'b1; step(); start = 1'b0;
    run_until(S_ARMED, 0, 50, npre, npost);
    chk("abort_armed", bus1.state_o, S_ARMED);
    chk("abort_pre_samples", npre, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("abort_idle", bus1.state_o, S_IDLE);
    chk("abort_outs", outs1(), 6'd0);
    chk("abort_idle_ar0", bus0.state_o, S_IDLE);
    step(); step();
    chk("abort_quiet", outs1(), 6'd0);

    // start and stop together in IDLE
    pretrig = 16'd2; num = 16'd5;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("startstop_idle", bus1.state_o, S_IDLE);
    chk("startstop_idle_ar0", bus0.state_o, S_IDLE);

    // Channel A disabled: B requested one cycle after entering READ_A
    cha_on = 1'b0; chb_on = 1'b1; pretrig = 16'd0; num = 16'd2;
    exp1.push_back(EV_B); exp1.push_back(EV_D);
    exp0.push_back(EV_D);
    start = 1'b1; step(); start = 1'b0;
    run_until(S_READ_A, 1, 100, npre, npost);
    chk("skip_reach_read_a", bus1.state_o, S_READ_A);
    chk("skip_no_rqst_a", bus1.rqst_chA_o, 1'b0);
    chk("skip_pre_samples", npre, 0);
    chk("skip_post_samples", npost, 1);
    step();
    chk("skip_read_b", bus1.state_o, S_READ_B);
    chk("skip_rqst_b", bus1.rqst_chB_o, 1'b1);
    finish_read(20);

    // Reset the AUTO_READOUT=0 instance during POST
    cha_on = 1'b1; chb_on = 1'b1; pretrig = 16'd0; num = 16'd20;
    exp1.push_back(EV_A); exp1.push_back(EV_B); exp1.push_back(EV_D);
    start = 1'b1; step(); start = 1'b0;
    run_until(S_POST, 1, 50, npre, npost);
    chk("rst_post_ar1", bus1.state_o, S_POST);
    chk("rst_post_ar0", bus0.state_o, S_POST);
    rst0_x = 1'b1; step(); rst0_x = 1'b0;
    chk("rst_ar0_state", bus0.state_o, S_IDLE);
    chk("rst_ar0_outs", outs0(), 6'd0);
    chk("rst_ar1_unaffected", bus1.state_o, S_POST);
    run_until(S_READ_A, 0, 120, npre, npost);
    chk("long_reach_read_a", bus1.state_o, S_READ_A);
    chk("long_post_samples", npost, 19);
    finish_read(20);

    step(); step();
    chk("ar1_queue_empty", exp1.size(), 0);
    chk("ar0_queue_empty", exp0.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/acquisition_sequencer.md
Name: acquisition_sequencer

Overview:
- Sequences one oscilloscope capture: pre-trigger fill, armed wait, post-trigger count, then channel readout requests.
- Drives the shared RAM write-enable for both channel blocks.
- Issues per-channel data requests toward the transmit path and tracks end-of-frame.
- Sits between the request decoder and trigger block on the control side, and the channel blocks and tx path on the data side.

Parameters:
REG_DATA_WIDTH, 16, width of pretrigger/num_samples values and internal sample counters
AUTO_READOUT, 1, 1 = request chA/chB data automatically after capture; 0 = finish at end of capture

Ports:
clk  input  1  system clock (100 MHz domain)
rst  input  1  synchronous, active-high reset
start_i  input  1  capture start pulse
stop_i  input  1  abort pulse
sample_rdy_i  input  1  ADC sample strobe, one cycle per sample
trigger_i  input  1  trigger event; qualified by sample_rdy_i
pretrigger_i  input  REG_DATA_WIDTH  samples to store before trigger
num_samples_i  input  REG_DATA_WIDTH  total samples per capture
chA_on_i  input  1  channel A enabled
chB_on_i  input  1  channel B enabled
chA_eof_i  input  1  channel A frame sent (tx_eof & tx_ack)
chB_eof_i  input  1  channel B frame sent
we_o  output  1  RAM write enable to both channel buffers
rqst_chA_o  output  1  one-cycle readout request, channel A
rqst_chB_o  output  1  one-cycle readout request, channel B
triggered_o  output  1  high from trigger until return to IDLE
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse on normal completion
state_o  output  3  current state encoding

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state IDLE; counters 0; all outputs 0.
- State encodings: IDLE=0, PRE=1, ARMED=2, POST=3, READ_A=4, READ_B=5, DONE=6.
- Start latch: pre_target and post_target are latched on start.
  - pre_target = min(pretrigger_i, num_samples_i-1).
  - post_target = num_samples_i - pre_target, which is always >= 1.
- IDLE:
  - start_i with num_samples_i != 0 -> PRE; counter cleared.
  - start_i with num_samples_i == 0 is ignored.
  - start_i and stop_i together: stop wins, stay IDLE.
- PRE:
  - we_o=1; counter increments on sample_rdy_i.
  - When counter == pre_target -> ARMED. With pre_target=0 this happens one cycle after entry.
  - trigger_i is ignored in PRE.
- ARMED:
  - we_o=1.
  - trigger_i & sample_rdy_i -> POST; counter loaded with 1 (the trigger sample counts); triggered_o set.
- POST:
  - we_o=1; counter increments on sample_rdy_i.
  - When counter == post_target -> READ_A if AUTO_READOUT=1, else DONE.
  - we_o falls on the cycle the state leaves POST. The last counted sample is written.
- READ_A:
  - If chA_on_i=1: rqst_chA_o pulses on the first cycle in state, then wait for chA_eof_i -> READ_B.
  - If chA_on_i=0: -> READ_B next cycle, no request.
- READ_B: same rule with the B signals; exits to DONE.
- DONE: done_o=1 for one cycle; triggered_o cleared; -> IDLE.
- stop_i in any non-IDLE state: -> IDLE next cycle; we_o=0, requests=0, triggered_o=0, no done_o.
- Ignored inputs:
  - start_i outside IDLE.
  - eof inputs outside their READ state.
  - sample_rdy_i in IDLE/READ/DONE states.
- Counter width: REG_DATA_WIDTH, no wrap. Equality is checked before increment, so the maximum num_samples (all ones) is reachable.
- Register inputs may change mid-capture; only values latched at start are used.
- Outputs are registered; latency from an input event to the state/output change is 1 cycle.

Test Plan:
- Nominal capture: pretrigger=4, num_samples=10, sample_rdy every 3rd cycle, trigger on the 7th sample.
  - we_o high from start+1 until 10 samples are written (4 pre + 6 post).
  - rqst_chA_o pulses once; chA_eof -> rqst_chB_o pulses; chB_eof -> done_o single pulse.
- Clamp: pretrigger=20, num_samples=8 -> ARMED after 7 samples; the trigger sample moves the block straight to READ_A (post_target=1).
- Zero-length request: num_samples=0 with start -> stays IDLE, busy_o=0, we_o=0.
- Abort:
  - stop_i asserted in ARMED -> IDLE next cycle, we_o=0, no rqst/done.
  - start+stop in the same IDLE cycle -> stays IDLE.
- Channel skip: chA_on=0, chB_on=1 -> no rqst_chA_o; rqst_chB_o pulses one cycle after entering READ_A.
- AUTO_READOUT=0, plus reset during POST:
  - Without reset, done_o fires right after POST.
  - rst during POST -> all outputs 0 next cycle, state_o=0.
